// File: rtl/core_pkg.sv
// Shared types and default widths for the memory arbiter.
//   arb_state_t : arbiter FSM states (idle, busy serving fetch, busy serving data)
//   arb_src_t   : requester identity (fetch or data)
package core_pkg;

  localparam int unsigned AddrWDefault   = 32;
  localparam int unsigned DataWDefault   = 32;
  localparam int unsigned TimeoutDefault = 255;
  localparam int unsigned WdogW          = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } arb_state_t;

  typedef enum logic {
    SrcI,
    SrcD
  } arb_src_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the requester that
// was not granted last; otherwise data always beats fetch and last_grant_i is ignored.
// Ports:
//   i_req, d_req  : fetch / data request levels
//   last_grant_i  : requester granted most recently
//   src_o         : winning requester (meaningful only when valid_o is high)
//   valid_o       : at least one request is pending
module mem_arb_pick
  import core_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_grant_i,
  output arb_src_t src_o,
  output logic     valid_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    valid_o = i_req | d_req;
    src_o   = SrcD;
    if (i_req && !d_req) begin
      src_o = SrcI;
    end else if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      src_o = (last_grant_i == SrcD) ? SrcI : SrcD;
`else
      src_o = SrcD;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data
// load/store. The winner's request is captured and held on the memory port until the
// memory acks or the watchdog reaches TIMEOUT, then the response is routed back.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- round-robin tie break (else data has priority).
// Ports:
//   clk, rst                         : clock, async active-high reset
//   i_req/i_addr -> i_ack/i_err/i_rdata : fetch requester
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_ack/d_err/d_rdata : data requester
//   m_req/m_we/m_addr/m_wdata/m_wstrb <- m_ack/m_rdata : shared memory port
module mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrWDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam logic [WdogW-1:0] TimeoutW = WdogW'(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [WdogW-1:0]    wdog_q, wdog_d;

  arb_src_t            last_grant;
  arb_src_t            pick_src;
  logic                pick_valid;

  logic                xfer_ack;
  logic                xfer_err;
  logic [DATA_W-1:0]   xfer_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_src_t last_q, last_d;
  assign last_grant = last_q;
`else
  assign last_grant = SrcI;
`endif

  mem_arb_pick u_pick (
    .i_req        (i_req),
    .d_req        (d_req),
    .last_grant_i (last_grant),
    .src_o        (pick_src),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wdog_d     = wdog_q;
    xfer_ack   = 1'b0;
    xfer_err   = 1'b0;
    xfer_rdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        // m_ack here is stale (e.g. after a timeout) and is deliberately dropped.
        if (pick_valid) begin
          wdog_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d = pick_src;
`endif
          if (pick_src == SrcD) begin
            state_d = StBusyD;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
          end else begin
            state_d = StBusyI;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      StBusyI, StBusyD: begin
        // A real ack beats a simultaneous watchdog expiry.
        if (m_ack) begin
          xfer_ack   = 1'b1;
          xfer_rdata = m_rdata;
          state_d    = StIdle;
        end else if (wdog_q == TimeoutW) begin
          xfer_ack = 1'b1;
          xfer_err = 1'b1;
          state_d  = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_req   = (state_q != StIdle);
    m_we    = we_q;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    m_wstrb = wstrb_q;

    i_ack   = 1'b0;
    i_err   = 1'b0;
    i_rdata = '0;
    d_ack   = 1'b0;
    d_err   = 1'b0;
    d_rdata = '0;
    if (state_q == StBusyI) begin
      i_ack   = xfer_ack;
      i_err   = xfer_err;
      i_rdata = xfer_rdata;
    end
    if (state_q == StBusyD) begin
      d_ack   = xfer_ack;
      d_err   = xfer_err;
      d_rdata = xfer_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wdog_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= SrcI;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wdog_q  <= wdog_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic          i_err;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_ack;
  logic          d_err;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    m_ack   = 1'b0;
    m_rdata = '0;
    tick();
    tick();

    // Reset state
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    rst = 1'b0;

    // Single fetch: memory acks one cycle after m_req rises
    i_req  = 1'b1;
    i_addr = 32'h100;
    chk("f_c0_m_req", m_req, 0);
    tick();
    chk("f_c1_m_req", m_req, 1);
    chk("f_c1_m_addr", m_addr, 32'h100);
    chk("f_c1_m_we", m_we, 0);
    chk("f_c1_i_ack", i_ack, 0);
    tick();
    m_ack   = 1'b1;
    m_rdata = 32'h00500093;
    #1;
    chk("f_i_ack", i_ack, 1);
    chk("f_i_rdata", i_rdata, 32'h00500093);
    chk("f_i_err", i_err, 0);
    chk("f_d_ack", d_ack, 0);
    tick();
    m_ack = 1'b0;
    i_req = 1'b0;
    #1;
    chk("f_after_m_req", m_req, 0);
    chk("f_after_i_ack", i_ack, 0);

    // Store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h2000;
    d_wdata = 32'hDEADBEEF;
    d_wstrb = 4'h3;
    tick();
    chk("s_m_we", m_we, 1);
    chk("s_m_wstrb", m_wstrb, 4'h3);
    chk("s_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("s_m_addr", m_addr, 32'h2000);
    chk("s_d_ack_pre", d_ack, 0);
    m_ack   = 1'b1;
    m_rdata = 32'h0;
    #1;
    chk("s_d_ack", d_ack, 1);
    chk("s_d_err", d_err, 0);
    chk("s_i_ack", i_ack, 0);
    tick();
    m_ack = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();

    // Tie, back-to-back; reset first so the round-robin pointer starts fetch-last
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_addr = 32'h300;
    d_addr = 32'h400;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      chk($sformatf("tie%0d_m_addr", k), m_addr, exp_d ? 32'h400 : 32'h300);
      m_ack   = 1'b1;
      m_rdata = 32'hA0 + k;
      #1;
      chk($sformatf("tie%0d_d_ack", k), d_ack, exp_d);
      chk($sformatf("tie%0d_i_ack", k), i_ack, !exp_d);
      tick();
      m_ack = 1'b0;
      #1;
      chk($sformatf("tie%0d_idle", k), m_req, 0);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

    // Address change mid-transaction is ignored
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h40;
    tick();
    chk("ac_m_addr0", m_addr, 32'h40);
    d_addr = 32'h80;
    tick();
    chk("ac_m_addr1", m_addr, 32'h40);
    m_ack   = 1'b1;
    m_rdata = 32'h55AA55AA;
    #1;
    chk("ac_d_ack", d_ack, 1);
    chk("ac_d_rdata", d_rdata, 32'h55AA55AA);
    chk("ac_m_addr2", m_addr, 32'h40);
    tick();
    m_ack = 1'b0;
    d_req = 1'b0;
    tick();

    // Timeout with TIMEOUT=4: grant at cycle 0, ack+err at cycle 5
    d_req  = 1'b1;
    d_addr = 32'h600;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to_c%0d_d_ack", c), d_ack, 0);
      chk($sformatf("to_c%0d_m_req", c), m_req, 1);
    end
    tick();
    chk("to_c5_d_ack", d_ack, 1);
    chk("to_c5_d_err", d_err, 1);
    chk("to_c5_d_rdata", d_rdata, 0);
    chk("to_c5_m_req", m_req, 1);
    tick();
    d_req = 1'b0;
    #1;
    chk("to_c6_m_req", m_req, 0);
    chk("to_c6_d_ack", d_ack, 0);
    m_ack   = 1'b1;
    m_rdata = 32'h1234;
    #1;
    chk("to_late_d_ack", d_ack, 0);
    chk("to_late_i_ack", i_ack, 0);
    tick();
    m_ack = 1'b0;
    tick();

    // m_ack on the very cycle the watchdog expires: ack wins, no error
    d_req = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    m_ack   = 1'b1;
    m_rdata = 32'hCAFE0001;
    #1;
    chk("tie_to_d_ack", d_ack, 1);
    chk("tie_to_d_err", d_err, 0);
    chk("tie_to_d_rdata", d_rdata, 32'hCAFE0001);
    tick();
    m_ack = 1'b0;
    d_req = 1'b0;
    tick();

    // Reset while BUSY_I with m_ack pending
    i_req  = 1'b1;
    i_addr = 32'h500;
    tick();
    chk("rb_m_req_busy", m_req, 1);
    m_ack   = 1'b1;
    m_rdata = 32'h77;
    rst     = 1'b1;
    #1;
    chk("rb_m_req_async", m_req, 0);
    chk("rb_i_ack", i_ack, 0);
    tick();
    m_ack = 1'b0;
    rst   = 1'b0;
    #1;
    chk("rb_idle_m_req", m_req, 0);
    tick();
    chk("rb_regrant_m_req", m_req, 1);
    chk("rb_regrant_m_addr", m_addr, 32'h500);
    m_ack   = 1'b1;
    m_rdata = 32'h88;
    #1;
    chk("rb_regrant_i_ack", i_ack, 1);
    chk("rb_regrant_i_rdata", i_rdata, 32'h88);
    tick();
    m_ack = 1'b0;
    i_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
